// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: the operation encoding and the bit positions of {N, Z, C, V}.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SHL  = 4'd5,
    ALU_SHR  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath for alu_pipe. With ALU_PIPE_FLAGS_EN defined it also
// produces {N, Z, C, V}; otherwise the adder is only WIDTH bits and no flags exist.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] result_o
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]       flags_o
`endif
);

  localparam int SH_W = $clog2(WIDTH);

  // The extra adder bit only exists when something consumes the carry.
`ifdef ALU_PIPE_FLAGS_EN
  localparam int SUM_W = WIDTH + 1;
`else
  localparam int SUM_W = WIDTH;
`endif

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] diff;
  logic [SH_W-1:0]  shamt;

  assign sum   = SUM_W'(a_i) + SUM_W'(b_i);
  assign diff  = SUM_W'(a_i) - SUM_W'(b_i);
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = sum[WIDTH-1:0];
      ALU_SUB:  result_o = diff[WIDTH-1:0];
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SHL:  result_o = a_i << shamt;
      ALU_SHR:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, a_i < b_i};
      default:  result_o = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  // Undefined encodings report all-zero flags, not Z=1 for their zero result.
  always_comb begin
    flags_o = '0;
    if (op_i <= ALU_SLTU) begin
      flags_o[FLAG_N] = result_o[WIDTH-1];
      flags_o[FLAG_Z] = (result_o == '0);
    end
    if (op_i == ALU_ADD) begin
      flags_o[FLAG_C] = sum[WIDTH];
      flags_o[FLAG_V] = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    end else if (op_i == ALU_SUB) begin
      flags_o[FLAG_C] = ~diff[WIDTH];
      flags_o[FLAG_V] = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
    end
  end
`endif

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: result computed at the input and carried through STAGES registers under
// valid/ready flow control. Define ALU_PIPE_FLAGS_EN to add the registered flags_o port.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [TAG_W-1:0] tag_o
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic [3:0]       flags_o
`endif
);

  logic [WIDTH-1:0]  core_result;
  logic [STAGES-1:0] load_ok;
  logic [STAGES-1:0] valid_d, valid_q;
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0]        core_flags;
  logic [3:0]        flags_d [STAGES];
  logic [3:0]        flags_q [STAGES];
`endif

  alu_pipe_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_i),
    .b_i      (b_i),
    .op_i     (op_i),
    .result_o (core_result)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .flags_o  (core_flags)
`endif
  );

  // A stage may load unless it and every stage ahead of it are full while the output stalls.
  always_comb begin : load_chain
    logic tail_full;
    tail_full = 1'b1;
    load_ok   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      tail_full  = tail_full & valid_q[k];
      load_ok[k] = !tail_full || out_ready_i;
    end
  end

  assign in_ready_o = load_ok[0];

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
`ifdef ALU_PIPE_FLAGS_EN
    flags_d = flags_q;
`endif
    if (load_ok[0]) begin
      valid_d[0] = in_valid_i;
      if (in_valid_i) begin
        data_d[0] = core_result;
        tag_d[0]  = tag_i;
`ifdef ALU_PIPE_FLAGS_EN
        flags_d[0] = core_flags;
`endif
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load_ok[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
`ifdef ALU_PIPE_FLAGS_EN
          flags_d[k] = flags_q[k-1];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
`ifdef ALU_PIPE_FLAGS_EN
        flags_q[k] <= '0;
`endif
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
        tag_q[k]  <= tag_d[k];
`ifdef ALU_PIPE_FLAGS_EN
        flags_q[k] <= flags_d[k];
`endif
      end
    end
  end

  assign out_valid_o = valid_q[STAGES-1];
  assign data_o      = data_q[STAGES-1];
  assign tag_o       = tag_q[STAGES-1];
`ifdef ALU_PIPE_FLAGS_EN
  assign flags_o     = flags_q[STAGES-1];
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8, STAGES=2); flag checks compile in only
// when ALU_PIPE_FLAGS_EN is defined.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] tag;
    logic [3:0] flags;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [3:0] tag;
    logic [7:0] d;
    logic [3:0] f;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic [3:0] op_in = '0;
  logic [3:0] tag_in = '0;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [7:0] data_o;
  logic [3:0] tag_o;
`ifdef ALU_PIPE_FLAGS_EN
  logic [3:0] flags_o;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .a_i         (a_in),
    .b_i         (b_in),
    .op_i        (alu_op_e'(op_in)),
    .tag_i       (tag_in),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .data_o      (data_o),
    .tag_o       (tag_o)
`ifdef ALU_PIPE_FLAGS_EN
    ,
    .flags_o     (flags_o)
`endif
  );

  // Reference ALU written with integer arithmetic, independent of the RTL structure.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op, input logic [3:0] tag);
    exp_t e;
    int   ua, ub, sa, sb, amt, r, sr;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    amt = ub % 8;
    r = 0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
      4'd1: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = ua << amt;
      4'd6: r = ua >> amt;
      4'd7: r = sa >>> amt;
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: r = (ua < ub) ? 1 : 0;
      default: r = 0;
    endcase
    e.data  = r[7:0];
    e.tag   = tag;
    e.flags = (op <= 4'd9) ? {e.data[7], e.data == 8'h00, c, v} : 4'b0000;
    return e;
  endfunction

  // One clock of stimulus: drive at the falling edge, observe 1 ns later.
  task automatic step(input logic iv, input logic ordy, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] op, input logic [3:0] tag,
                      output logic acc, output logic fire);
    @(negedge clk);
    in_valid  = iv;
    out_ready = ordy;
    a_in      = a;
    b_in      = b;
    op_in     = op;
    tag_in    = tag;
    #1;
    acc  = iv && in_ready_o;
    fire = out_valid_o && ordy;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_ni    = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || data_o !== 8'h00 || tag_o !== 4'h0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b data=%h tag=%h in_ready=%b, want 0 00 0 1",
               out_valid_o, data_o, tag_o, in_ready_o);
    end
`ifdef ALU_PIPE_FLAGS_EN
    checks++;
    if (flags_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 0000", flags_o);
    end
`endif
  endtask

  task automatic test_directed();
    vec_t vecs[12];
    logic acc, fire;
    int   n;
    vecs[0]  = {8'hFF, 8'h01, 4'd0,  4'h3, 8'h00, 4'b0110};
    vecs[1]  = {8'h80, 8'h01, 4'd1,  4'h5, 8'h7F, 4'b0011};
    vecs[2]  = {8'h80, 8'h01, 4'd8,  4'h6, 8'h01, 4'b0000};
    vecs[3]  = {8'h80, 8'h01, 4'd9,  4'h7, 8'h00, 4'b0100};
    vecs[4]  = {8'h90, 8'h0A, 4'd7,  4'h8, 8'hE4, 4'b1000};
    vecs[5]  = {8'h90, 8'h0A, 4'd6,  4'h9, 8'h24, 4'b0000};
    vecs[6]  = {8'h81, 8'h01, 4'd5,  4'hA, 8'h02, 4'b0000};
    vecs[7]  = {8'hF0, 8'h3C, 4'd2,  4'hB, 8'h30, 4'b0000};
    vecs[8]  = {8'hF0, 8'h0F, 4'd3,  4'hC, 8'hFF, 4'b1000};
    vecs[9]  = {8'hAA, 8'hAA, 4'd4,  4'hD, 8'h00, 4'b0100};
    vecs[10] = {8'h7F, 8'h01, 4'd0,  4'hE, 8'h80, 4'b1001};
    vecs[11] = {8'h55, 8'h33, 4'd12, 4'hF, 8'h00, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, acc, fire);
      checks++;
      if (!acc) begin
        errors++;
        $display("[TB] FAIL dir_accept[%0d]: in_ready=%b want 1", i, in_ready_o);
      end
      n = 0;
      fire = 1'b0;
      while (!fire && n < 10) begin
        n++;
        step(1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 4'h0, acc, fire);
      end
      checks++;
      if (n != STAGES) begin
        errors++;
        $display("[TB] FAIL dir_latency[%0d]: output after %0d cycles want %0d", i, n, STAGES);
      end
      checks++;
      if (data_o !== vecs[i].d || tag_o !== vecs[i].tag) begin
        errors++;
        $display("[TB] FAIL dir_result[%0d]: data=%h tag=%h want %h %h",
                 i, data_o, tag_o, vecs[i].d, vecs[i].tag);
      end
`ifdef ALU_PIPE_FLAGS_EN
      checks++;
      if (flags_o !== vecs[i].f) begin
        errors++;
        $display("[TB] FAIL dir_flags[%0d]: got %b want %b", i, flags_o, vecs[i].f);
      end
`endif
    end
  endtask

  task automatic test_stream();
    logic       acc, fire, iv, ordy;
    logic [7:0] a, b;
    logic [3:0] op;
    int         sent, recv, cyc;
    exp_t       e;
    sent = 0;
    recv = 0;
    cyc  = 0;
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 4'($urandom_range(0, 11));
    while ((sent < 20 || recv < 20) && cyc < 600) begin
      cyc++;
      iv   = (sent < 20) && ($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      step(iv, ordy, a, b, op, 4'(sent), acc, fire);
      if (out_valid_o) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL stream_spurious: out_valid with empty scoreboard, data=%h", data_o);
        end else begin
          e = sb_q[0];
          if (data_o !== e.data || tag_o !== e.tag) begin
            errors++;
            $display("[TB] FAIL stream_data: data=%h tag=%h want %h %h", data_o, tag_o, e.data, e.tag);
          end
`ifdef ALU_PIPE_FLAGS_EN
          else if (flags_o !== e.flags) begin
            errors++;
            $display("[TB] FAIL stream_flags: got %b want %b", flags_o, e.flags);
          end
`endif
          if (fire) begin
            void'(sb_q.pop_front());
            recv++;
          end
        end
      end
      if (acc) begin
        sb_q.push_back(model(a, b, op, 4'(sent)));
        sent++;
        a  = 8'($urandom);
        b  = 8'($urandom);
        op = 4'($urandom_range(0, 11));
      end
    end
    checks++;
    if (recv != 20 || sent != 20 || sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL stream_count: sent=%0d received=%0d pending=%0d want 20 20 0",
               sent, recv, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic       acc, fire;
    logic [7:0] a, b;
    logic [3:0] op;
    int         accepts, drain;
    exp_t       e;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 4'($urandom_range(0, 9));
      step(1'b1, 1'b0, a, b, op, 4'(i), acc, fire);
      if (!acc) break;
      sb_q.push_back(model(a, b, op, 4'(i)));
      accepts++;
    end
    checks++;
    if (accepts != STAGES || in_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_depth: accepted %0d in_ready=%b want %0d 0", accepts, in_ready_o, STAGES);
    end
    for (int i = 0; i < 8; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 4'($urandom_range(0, 9));
      step(1'b1, 1'b1, a, b, op, 4'(8 + i), acc, fire);
      checks++;
      if (!acc || !fire) begin
        errors++;
        $display("[TB] FAIL b2b_rate[%0d]: accept=%b output=%b want 1 1", i, acc, fire);
      end
      if (fire && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (data_o !== e.data || tag_o !== e.tag) begin
          errors++;
          $display("[TB] FAIL b2b_data[%0d]: data=%h tag=%h want %h %h", i, data_o, tag_o, e.data, e.tag);
        end
      end
      if (acc) sb_q.push_back(model(a, b, op, 4'(8 + i)));
    end
    drain = 0;
    while (sb_q.size() != 0 && drain < 20) begin
      drain++;
      step(1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 4'h0, acc, fire);
      if (fire) begin
        e = sb_q.pop_front();
        checks++;
        if (data_o !== e.data || tag_o !== e.tag) begin
          errors++;
          $display("[TB] FAIL drain_data: data=%h tag=%h want %h %h", data_o, tag_o, e.data, e.tag);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results still pending want 0", sb_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic acc, fire;
    int   inflight;
    inflight = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 8'(i + 3), 8'h04, 4'd0, 4'(i + 1), acc, fire);
      if (acc) inflight++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checks++;
    if (inflight != 2 || out_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: inflight=%0d out_valid=%b want 2 1", inflight, out_valid_o);
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || data_o !== 8'h00 || tag_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b data=%h tag=%h want 0 00 0", out_valid_o, data_o, tag_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    sb_q.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'h00, 8'h00, 4'd0, 4'h0, acc, fire);
      checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stale_after_reset[%0d]: valid=%b in_ready=%b want 0 1", i, out_valid_o, in_ready_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Pipelined, parametrised successor to the combinational ALU. Accepts one operation per cycle on a valid/ready handshake, computes it in a configurable number of register stages, and returns the result with an optional flag set and a caller-supplied tag. Sits between an issue stage and a writeback stage that can exert backpressure.

## Interface
- WIDTH, 32: operand and result width, ≥ 8, power of two.
- STAGES, 2: pipeline register stages, 1..4 (latency in cycles).
- TAG_W, 4: width of the pass-through tag.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operation presented.
- in_ready_o  out  1  pipe can accept this cycle.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B / shift amount.
- op_i  in  alu_op_e  operation select.
- tag_i  in  TAG_W  caller tag, returned unchanged.
- out_valid_o  out  1  result presented.
- out_ready_i  in  1  consumer accepts result.
- data_o  out  WIDTH  result.
- tag_o  out  TAG_W  tag of the presented result.
- flags_o  out  4  {N, Z, C, V}; present only with ALU_PIPE_FLAGS_EN.

## Operation
- Ops: ADD, SUB, AND, OR, XOR, SHL, SHR (logical), SRA (arithmetic), SLT (signed, result 1/0), SLTU (unsigned, result 1/0). Any other encoding: data 0, flags 0, still travels the pipe normally.
- Shift amount = b_i[$clog2(WIDTH)-1:0]; upper bits of b_i ignored.
- All arithmetic modulo 2^WIDTH.
- Result computed combinationally at input, captured in stage 0; stages 1..STAGES-1 are pure registers (data, tag, flags, valid).
- Transfer in when in_valid_i && in_ready_o; out when out_valid_o && out_ready_i.
- Stage k advances when stage k+1 is empty or advancing; last stage advances on out_ready_i. in_ready_o = !valid[0] || stage 0 advancing (combinational chain from out_ready_i; no skid buffer).
- Bubbles collapse: an empty stage accepts from the stage behind it even when downstream is stalled.
- Data, tag and flags must hold stable while out_valid_o && !out_ready_i.

## Timing
- Reset (async assert, sync release): all valid bits 0, data_o 0, tag_o 0, flags_o 0, out_valid_o 0; in_ready_o 1 after reset.
- Latency: accepted at edge t -> out_valid_o high after edge t+STAGES-1 (STAGES=1: visible the cycle after acceptance).
- Throughput: 1 op/cycle with out_ready_i held high.
- Full pipe + out_ready_i low: in_ready_o 0; accepted ops never lost or duplicated.
- Simultaneous in/out transfer at full pipe: allowed, occupancy unchanged.
- Reset mid-operation: all in-flight ops discarded, no output afterwards.

## Configuration
- ALU_PIPE_FLAGS_EN defined: flags_o port present. N = result MSB; Z = result == 0; C = carry-out for ADD, NOT borrow for SUB, 0 otherwise; V = signed overflow for ADD/SUB, 0 otherwise. Flags registered alongside data.
- Undefined: flags_o port and flag registers absent; all other behaviour identical.

## Structure
- Package alu_pipe_pkg: alu_op_e enum (ADD=0 … SLTU=9, 4-bit), flag bit index constants FLAG_N/Z/C/V.
- Sub-module alu_pipe_core: combinational op/flag compute, parametrised by WIDTH; alu_pipe wraps it with the STAGES register/handshake chain.

## Test plan
- WIDTH=8, STAGES=2: ADD 0xFF+0x01, tag 3 -> data 0x00, Z=1, C=1, V=0, tag 3, two cycles after acceptance.
- SUB 0x80-0x01 -> 0x7F, V=1, C=1; SLT 0x80,0x01 -> 1; SLTU 0x80,0x01 -> 0.
- SRA 0x90 by b=0x0A (amount 2) -> 0xE4; SHR same -> 0x24; SHL 0x81 by 1 -> 0x02.
- Stream 20 ops with random out_ready_i (50%): scoreboard sees all 20 in order, matching tags, data stable during stalls.
- Fill pipe with out_ready_i=0 -> in_ready_o 0 after STAGES accepts; raise out_ready_i with in_valid_i high -> 1 op/cycle both ends.
- Assert rst_ni mid-stream with 2 ops in flight -> out_valid_o 0 immediately, no stale result after release; rebuild without ALU_PIPE_FLAGS_EN and rerun stream test.
